// File: rtl/seq_pattern_tx_pkg.sv
// seq_pattern_tx_pkg: shared types and constants for the pattern serializer.
// The PARITY state is always declared here. It is only reachable when
// SEQ_PATTERN_TX_PARITY_EN is defined.
package seq_pattern_tx_pkg;

    // Width of the repetition count input and of the remaining-repetition register.
    localparam int REPEAT_W = 4;

    // Transmitter states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2,
        PARITY = 2'd3
    } state_t;

endpackage

// File: rtl/seq_pattern_tx_flex_counter.sv
// flex_counter: the team's counter with a programmable rollover value.
// When enabled, it counts 1..rollover_val_i and then wraps back to 1.
// clear_i forces the count to 0.
// rollover_flag_o is registered. It is high while count_o equals rollover_val_i.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear_i,
    input  logic                    count_enable_i,
    input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
    output logic [NUM_CNT_BITS-1:0] count_o,
    output logic                    rollover_flag_o
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear wins. Otherwise step, wrapping to 1 at the rollover value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            if (count_q == rollover_val_i) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        flag_d = (count_d == rollover_val_i) && !clear_i;
    end

    // Count and flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_o         = count_q;
    assign rollover_flag_o = flag_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serializes a captured pattern MSB first, repeat_cnt+1 times.
// The repetitions follow one another with no gap, and the transfer ends with
// a one-cycle done pulse. All outputs are registered Moore outputs.
// Optional feature: define SEQ_PATTERN_TX_PARITY_EN to append one even-parity
// cycle after every repetition.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int   DATA_BITS  = 4,
    parameter logic IDLE_VALUE = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pattern,
    input  logic [REPEAT_W-1:0]  repeat_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 serial_out
);

    // The counter must be able to hold DATA_BITS itself (the rollover value).
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    state_t                state_q, state_d;
    logic [REPEAT_W-1:0]   rep_q, rep_d;
    logic [DATA_BITS-1:0]  pattern_q, pattern_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  serial_q, serial_d;

    logic                  cnt_clear;
    logic                  cnt_en;
    logic [CNT_W-1:0]      cnt_out;
    logic                  cnt_roll;
    logic [IDX_W-1:0]      bit_idx;
    logic                  rep_end;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction

    // cnt_out counts the bits of the current repetition already on the line
    // (1..DATA_BITS). The flag marks the cycle where bit 0 is being driven.
    flex_counter #(
        .NUM_CNT_BITS(CNT_W)
    ) u_bit_cnt (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear_i        (cnt_clear),
        .count_enable_i (cnt_en),
        .rollover_val_i (CNT_W'(DATA_BITS)),
        .count_o        (cnt_out),
        .rollover_flag_o(cnt_roll)
    );

    // Index of the bit to drive next: after k bits sent, the next one is DATA_BITS-1-k.
    assign bit_idx = IDX_W'(DATA_BITS - 1 - int'(cnt_out));

    // Next-state logic. Outputs are computed for the next state so that they
    // come out of registers.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        pattern_d = pattern_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        serial_d  = IDLE_VALUE;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        rep_end   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    pattern_d = pattern;
                    rep_d     = repeat_cnt;
                    busy_d    = 1'b1;
                    serial_d  = pattern[DATA_BITS-1];
                    cnt_en    = 1'b1;
                end
            end
            SHIFT: begin
                if (!cnt_roll) begin
                    busy_d   = 1'b1;
                    serial_d = pattern_q[bit_idx];
                    cnt_en   = 1'b1;
                end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    state_d  = PARITY;
                    busy_d   = 1'b1;
                    serial_d = even_parity(pattern_q);
`else
                    rep_end  = 1'b1;
`endif
                end
            end
`ifdef SEQ_PATTERN_TX_PARITY_EN
            PARITY: begin
                rep_end = 1'b1;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                cnt_clear = 1'b1;
            end
        endcase

        // End of one repetition: either restart at the MSB, or finish.
        if (rep_end) begin
            if (rep_q != '0) begin
                rep_d    = rep_q - 1'b1;
                busy_d   = 1'b1;
                serial_d = pattern_q[DATA_BITS-1];
                cnt_en   = 1'b1;
                state_d  = SHIFT;
            end else begin
                state_d   = DONE;
                done_d    = 1'b1;
                cnt_clear = 1'b1;
            end
        end
    end

    // Control and output registers. Reset returns them to idle at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            rep_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            serial_q <= IDLE_VALUE;
        end else begin
            state_q  <= state_d;
            rep_q    <= rep_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            serial_q <= serial_d;
        end
    end

    // Captured pattern. It is only read while a transfer is active, so it has no reset.
    always_ff @(posedge clk) begin
        pattern_q <= pattern_d;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign serial_out = serial_q;

endmodule
